// File: rtl/nd2d2_invd2_ring_osc.sv
// Cycle-based model of an enable-gated ring oscillator: a NAND head stage
// followed by STAGES-1 inverters, one gate delay per clock. A load inverter
// drives OUT, and OUT's rising edges are counted and timed so the ring can
// be characterised without a real combinational loop.
module nd2d2_invd2_ring_osc #(
    parameter int STAGES = 101,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN_VCO,
    output logic              OUT,
    output logic [STAGES-1:0] TAP,
    output logic [CNT_W-1:0]  RISE_CNT,
    output logic [CNT_W-1:0]  PERIOD,
    output logic              PERIOD_VLD
);

    // An even or too-short ring would latch rather than oscillate.
    generate
        if ((STAGES < 3) || ((STAGES % 2) == 0)) begin : g_bad_stages
            $error("nd2d2_invd2_ring_osc: STAGES must be odd and >= 3");
        end
    endgenerate

    // Node bit gi holds w[gi+1]; bit 0 is the NAND output, the MSB is the tail.
    logic [STAGES-1:0] w_reg;
    logic [STAGES-1:0] w_next;
    logic [STAGES-1:0] rest_val;

    logic              out_q_reg;
    logic              seen_rise_reg;
    logic [CNT_W-1:0]  cyc_reg;
    logic [CNT_W-1:0]  cyc_next;
    logic [CNT_W-1:0]  rise_cnt_reg;
    logic [CNT_W-1:0]  period_reg;
    logic              period_vld_reg;
    logic              rise;

    // Head stage: NAND of enable and the ring tail.
    assign w_next[0] = ~(EN_VCO & w_reg[STAGES-1]);

    // Inverter chain: every stage takes the inverse of its predecessor.
    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_inv
            assign w_next[gi] = ~w_reg[gi-1];
        end
    endgenerate

    // Rest pattern: odd-numbered nodes high, even-numbered nodes low.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_rest
            assign rest_val[gi] = ((gi % 2) == 0);
        end
    endgenerate

    assign OUT        = ~w_reg[STAGES-1];
    assign TAP        = w_reg;
    assign RISE_CNT   = rise_cnt_reg;
    assign PERIOD     = period_reg;
    assign PERIOD_VLD = period_vld_reg;

    // A rise is seen one edge after OUT goes high, against the previous copy.
    assign rise = OUT & ~out_q_reg;

    // Cycle counter restarts at 1 on a rise so its value at the next rise is
    // the full rise-to-rise distance; it sticks at all-ones instead of wrapping.
    always_comb begin
        cyc_next = cyc_reg;
        if (rise) begin
            cyc_next = CNT_W'(1);
        end else if (!(&cyc_reg)) begin
            cyc_next = cyc_reg + CNT_W'(1);
        end
    end

    // Advance all ring nodes together, one gate delay per clock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_reg <= rest_val;
        end else begin
            w_reg <= w_next;
        end
    end

    // Rise counting and period capture; PERIOD is only valid from the second rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q_reg      <= 1'b0;
            seen_rise_reg  <= 1'b0;
            cyc_reg        <= '0;
            rise_cnt_reg   <= '0;
            period_reg     <= '0;
            period_vld_reg <= 1'b0;
        end else begin
            out_q_reg <= OUT;
            cyc_reg   <= cyc_next;
            if (rise) begin
                rise_cnt_reg  <= rise_cnt_reg + CNT_W'(1);
                seen_rise_reg <= 1'b1;
                if (seen_rise_reg) begin
                    period_reg     <= cyc_reg;
                    period_vld_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nd2d2_invd2_ring_osc.sv
// Directed bench for nd2d2_invd2_ring_osc: three instances with different
// ring lengths / counter widths, each exercised in turn with edge-indexed
// checkpoints whose expected values were worked out by hand.
module tb_nd2d2_invd2_ring_osc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // STAGES=5, CNT_W=16
    logic        rst5 = 1'b1, en5 = 1'b0;
    logic        out5, vld5;
    logic [4:0]  tap5;
    logic [15:0] rise5, per5;

    // STAGES=101 (default), CNT_W=16
    logic         rst101 = 1'b1, en101 = 1'b0;
    logic         out101, vld101;
    logic [100:0] tap101;
    logic [15:0]  rise101, per101;

    // STAGES=3, CNT_W=4
    logic        rst3 = 1'b1, en3 = 1'b0;
    logic        out3, vld3;
    logic [2:0]  tap3;
    logic [3:0]  rise3, per3;

    nd2d2_invd2_ring_osc #(.STAGES(5), .CNT_W(16)) dut5 (
        .CLK(clk), .RST(rst5), .EN_VCO(en5), .OUT(out5), .TAP(tap5),
        .RISE_CNT(rise5), .PERIOD(per5), .PERIOD_VLD(vld5)
    );

    nd2d2_invd2_ring_osc dut101 (
        .CLK(clk), .RST(rst101), .EN_VCO(en101), .OUT(out101), .TAP(tap101),
        .RISE_CNT(rise101), .PERIOD(per101), .PERIOD_VLD(vld101)
    );

    nd2d2_invd2_ring_osc #(.STAGES(3), .CNT_W(4)) dut3 (
        .CLK(clk), .RST(rst3), .EN_VCO(en3), .OUT(out3), .TAP(tap3),
        .RISE_CNT(rise3), .PERIOD(per3), .PERIOD_VLD(vld3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock edge; sample and drive 1 time unit after it.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // ---------------- STAGES=5: reset, start, period, disable ----------
        rst5 = 1'b1; en5 = 1'b1;
        step(2);
        chk("s5 reset TAP", 32'(tap5), 32'h15);
        chk("s5 reset OUT", 32'(out5), 0);
        chk("s5 reset RISE_CNT", 32'(rise5), 0);
        chk("s5 reset PERIOD", 32'(per5), 0);
        chk("s5 reset PERIOD_VLD", 32'(vld5), 0);
        rst5 = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            step(1);
            if (k == 1)  chk("s5 e1 w1 fell TAP", 32'(tap5), 32'h14);
            if (k == 4)  chk("s5 e4 OUT", 32'(out5), 0);
            if (k == 5)  chk("s5 e5 OUT rise", 32'(out5), 1);
            if (k == 5)  chk("s5 e5 RISE_CNT", 32'(rise5), 0);
            if (k == 6)  chk("s5 e6 RISE_CNT", 32'(rise5), 1);
            if (k == 9)  chk("s5 e9 OUT", 32'(out5), 1);
            if (k == 10) chk("s5 e10 OUT fall", 32'(out5), 0);
            if (k == 15) chk("s5 e15 OUT", 32'(out5), 1);
            if (k == 15) chk("s5 e15 PERIOD_VLD", 32'(vld5), 0);
            if (k == 16) chk("s5 e16 PERIOD_VLD", 32'(vld5), 1);
            if (k == 16) chk("s5 e16 PERIOD", 32'(per5), 10);
            if (k == 20) chk("s5 e20 OUT", 32'(out5), 0);
            if (k == 30) chk("s5 e30 RISE_CNT", 32'(rise5), 3);
            if (k == 37) chk("s5 e37 OUT", 32'(out5), 1);
            if (k == 37) chk("s5 e37 RISE_CNT", 32'(rise5), 4);
        end
        en5 = 1'b0;
        step(5);
        chk("s5 drain TAP", 32'(tap5), 32'h15);
        chk("s5 drain OUT", 32'(out5), 0);
        step(10);
        chk("s5 rest TAP", 32'(tap5), 32'h15);
        chk("s5 rest RISE_CNT", 32'(rise5), 4);
        chk("s5 rest PERIOD", 32'(per5), 10);
        chk("s5 rest PERIOD_VLD", 32'(vld5), 1);

        // ---------------- STAGES=101 default ------------------------------
        rst101 = 1'b1; en101 = 1'b1;
        step(2);
        chk("s101 reset OUT", 32'(out101), 0);
        rst101 = 1'b0;
        for (int k = 1; k <= 520; k++) begin
            step(1);
            if (k == 100) chk("s101 e100 OUT", 32'(out101), 0);
            if (k == 101) chk("s101 e101 OUT rise", 32'(out101), 1);
            if (k == 201) chk("s101 e201 OUT", 32'(out101), 1);
            if (k == 202) chk("s101 e202 OUT fall", 32'(out101), 0);
            if (k == 302) chk("s101 e302 OUT", 32'(out101), 0);
            if (k == 303) chk("s101 e303 OUT rise", 32'(out101), 1);
            if (k == 304) chk("s101 e304 PERIOD_VLD", 32'(vld101), 1);
            if (k == 304) chk("s101 e304 PERIOD", 32'(per101), 202);
            if (k == 505) chk("s101 e505 OUT rise", 32'(out101), 1);
            if (k == 520) chk("s101 e520 RISE_CNT", 32'(rise101), 3);
            if (k == 520) chk("s101 e520 PERIOD", 32'(per101), 202);
        end

        // ---------------- STAGES=3, CNT_W=4: reset mid-run, wrap, saturate -
        rst3 = 1'b1; en3 = 1'b1;
        step(2);
        rst3 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            if (k == 3) chk("s3 e3 OUT rise", 32'(out3), 1);
            if (k == 6) chk("s3 e6 OUT fall", 32'(out3), 0);
        end
        chk("s3 e11 OUT", 32'(out3), 1);
        chk("s3 e11 RISE_CNT", 32'(rise3), 2);
        chk("s3 e11 PERIOD", 32'(per3), 6);
        rst3 = 1'b1;
        step(1);
        chk("s3 midrst TAP", 32'(tap3), 32'h5);
        chk("s3 midrst OUT", 32'(out3), 0);
        chk("s3 midrst RISE_CNT", 32'(rise3), 0);
        chk("s3 midrst PERIOD", 32'(per3), 0);
        chk("s3 midrst PERIOD_VLD", 32'(vld3), 0);
        step(1);
        rst3 = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            if (k == 4)  chk("s3 e4 RISE_CNT", 32'(rise3), 1);
            if (k == 99) chk("s3 e99 RISE_CNT 16 wraps", 32'(rise3), 0);
            if (k == 100) chk("s3 e100 RISE_CNT 17", 32'(rise3), 1);
            if (k == 100) chk("s3 e100 PERIOD", 32'(per3), 6);
        end
        en3 = 1'b0;
        step(20);
        chk("s3 idle TAP", 32'(tap3), 32'h5);
        chk("s3 idle PERIOD_VLD", 32'(vld3), 1);
        chk("s3 idle PERIOD", 32'(per3), 6);
        en3 = 1'b1;
        step(4);
        chk("s3 restart RISE_CNT", 32'(rise3), 2);
        chk("s3 restart PERIOD saturated", 32'(per3), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
